// File: rtl/panel_scroll_ctrl.sv
// Scroll sequencer for a shift-register LED panel: broadcasts a 2-bit cell select,
// paces shifts with a prescaler and tracks the scroll offset.
module panel_scroll_ctrl #(
  parameter int LEN_W = 6,
  parameter int SPD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  input  logic [SPD_W-1:0] speed,
  input  logic [LEN_W-1:0] length,
  output logic             sel0,
  output logic             sel1,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pos,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured on the IDLE->LOAD edge
  logic             dir_q;
  logic             mode_q;
  logic [SPD_W-1:0] speed_q;
  logic [LEN_W-1:0] len_q;

  logic [SPD_W-1:0] presc;

  logic start_ok;
  logic wrap;
  logic step_due;

  logic [1:0] sel_nxt;
  logic       load_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  assign start_ok  = start && !stop && (length != '0);
  assign wrap      = (pos == len_q - LEN_W'(1));
  assign step_due  = (presc == speed_q);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop overrides every transition out of a busy state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = stop ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (step_due) begin
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (wrap && !mode_q) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with state
  always_comb begin
    sel_nxt  = 2'b01;
    load_nxt = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_LOAD: begin
        sel_nxt  = 2'b00;
        load_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_WAIT: begin
        busy_nxt = 1'b1;
      end
      S_SHIFT: begin
        sel_nxt  = dir_q ? 2'b10 : 2'b11;
        busy_nxt = 1'b1;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        sel_nxt = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel1 <= 1'b0;
      sel0 <= 1'b0;
      load <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sel1 <= sel_nxt[1];
      sel0 <= sel_nxt[0];
      load <= load_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Configuration, prescaler and scroll offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      speed_q <= '0;
      len_q   <= '0;
      presc   <= '0;
      pos     <= '0;
    end else begin
      if (state == S_IDLE && state_nxt == S_LOAD) begin
        dir_q   <= dir;
        mode_q  <= mode;
        speed_q <= speed;
        len_q   <= length;
      end

      if (state == S_WAIT && state_nxt == S_WAIT) begin
        presc <= presc + SPD_W'(1);
      end else begin
        presc <= '0;
      end

      // An aborted SHIFT leaves the offset where it was
      if (state_nxt == S_LOAD) begin
        pos <= '0;
      end else if (state == S_SHIFT && state_nxt != S_IDLE) begin
        pos <= wrap ? '0 : pos + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_panel_scroll_ctrl.sv
// Bench for panel_scroll_ctrl: timeline-based reference model with a per-cycle
// scoreboard, directed scenarios with literal expectations, then random traffic.
module tb_panel_scroll_ctrl;

  localparam int LW = 6;
  localparam int SW = 4;
  localparam int EW = 2 + 3 + LW;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic          dir    = 1'b0;
  logic          mode   = 1'b0;
  logic [SW-1:0] speed  = '0;
  logic [LW-1:0] length = '0;
  logic          sel0, sel1, load, busy, done;
  logic [LW-1:0] pos;
  logic [2:0]    dbg_state;

  panel_scroll_ctrl #(.LEN_W(LW), .SPD_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .speed(speed), .length(length), .sel0(sel0), .sel1(sel1), .load(load),
    .busy(busy), .done(done), .pos(pos), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a scroll is a timeline indexed by k, the cycle count since LOAD entry (k=1)
  bit m_rst  = 1'b1;
  bit m_act  = 1'b0;
  int m_k    = 0;
  int m_len  = 1;
  int m_spd  = 0;
  bit m_dir  = 1'b0;
  bit m_mode = 1'b0;
  int m_idle_pos = 0;
  logic [EW-1:0] exp_q[$];

  function automatic void model_out(input int k, output logic [1:0] s, output logic ld,
                                    output logic bz, output logic dn, output int p);
    int per;
    int m;
    per = m_spd + 2;
    s = 2'b01; ld = 1'b0; bz = 1'b1; dn = 1'b0; p = 0;
    if (k == 1) begin
      s = 2'b00; ld = 1'b1;
    end else if (!m_mode && k == 2 + m_len * per) begin
      bz = 1'b0; dn = 1'b1;
    end else begin
      m = k - 2;
      p = (m / per) % m_len;
      if (m % per == per - 1) s = m_dir ? 2'b10 : 2'b11;
    end
  endfunction

  function automatic logic [EW-1:0] model_vec();
    logic [1:0] s;
    logic ld, bz, dn;
    int p;
    if (m_rst) return '0;
    if (!m_act) return {2'b01, 3'b000, LW'(m_idle_pos)};
    model_out(m_k, s, ld, bz, dn, p);
    return {s, ld, bz, dn, LW'(p)};
  endfunction

  initial forever begin
    logic [1:0] s;
    logic ld, bz, dn;
    int p;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_rst = 1'b1; m_act = 1'b0; m_idle_pos = 0;
      exp_q.delete();
    end else begin
      m_rst = 1'b0;
      if (m_act) begin
        model_out(m_k, s, ld, bz, dn, p);
        if (dn) begin
          m_act = 1'b0; m_idle_pos = 0;
        end else if (stop) begin
          m_act = 1'b0; m_idle_pos = p;
        end else begin
          m_k++;
        end
      end else if (start && !stop && length != 0) begin
        m_act = 1'b1; m_k = 1;
        m_len = int'(length); m_spd = int'(speed); m_dir = dir; m_mode = mode;
      end
    end
    exp_q.push_back(model_vec());
  end

  // Scoreboard compare on every falling edge
  initial forever begin
    logic [EW-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("outputs{sel,load,busy,done,pos}", {21'b0, sel1, sel0, load, busy, done, pos}, {21'b0, e});
    end
  end

  // Driver tasks
  task automatic pulse_start(input int len, input int spd, input bit d, input bit m);
    length = LW'(len); speed = SW'(spd); dir = d; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the config inputs; the running scroll must keep the latched values
    length = LW'($urandom_range(1, 63)); speed = SW'($urandom_range(0, 15));
    dir = 1'($urandom); mode = 1'($urandom);
  endtask

  initial begin
    int ndone;
    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("reset_sel", {sel1, sel0}, 2'b00);
    check("reset_busy_load_done", {busy, load, done}, 3'b000);
    check("reset_pos", pos, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("idle_sel_after_reset", {sel1, sel0}, 2'b01);

    // length=4 speed=1 dir=0 single pass
    pulse_start(4, 1, 1'b0, 1'b0);
    check("p1_load_k1", load, 1'b1);
    check("p1_sel_k1", {sel1, sel0}, 2'b00);
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      check("p1_sel", {sel1, sel0}, (k == 4 || k == 7 || k == 10 || k == 13) ? 2'b11 : 2'b01);
      check("p1_done", done, (k == 14));
      check("p1_busy", busy, (k < 14));
      check("p1_pos", pos, (k >= 5 && k <= 7) ? 1 : (k >= 8 && k <= 10) ? 2 :
                           (k >= 11 && k <= 13) ? 3 : 0);
    end

    // length=3 speed=0 dir=1 continuous, then stop in WAIT
    pulse_start(3, 0, 1'b1, 1'b1);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      check("p2_sel", {sel1, sel0}, (k % 2 == 1) ? 2'b10 : 2'b01);
      check("p2_done", done, 1'b0);
      check("p2_pos", pos, ((k - 2) / 2) % 3);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("p2_stop_sel", {sel1, sel0}, 2'b01);
    check("p2_stop_busy", busy, 1'b0);
    check("p2_stop_pos", pos, 0);

    // stop on the edge where WAIT would enter SHIFT
    pulse_start(5, 2, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("p3_no_shift_sel", {sel1, sel0}, 2'b01);
    check("p3_busy", busy, 1'b0);
    check("p3_pos_held", pos, 1);

    // start with length 0 ignored; stop+start in IDLE ignored
    length = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("p4_len0_busy", busy, 1'b0);
    check("p4_len0_load", load, 1'b0);
    length = LW'(3); start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("p4_stopstart_busy", {busy, load}, 2'b00);

    // start while busy is ignored; pass keeps the latched length of 5
    pulse_start(5, 0, 1'b0, 1'b0);
    ndone = 0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      check("p4_done_timing", done, (k == 12));
      if (done === 1'b1) ndone++;
      if (k == 4) begin
        start = 1'b1; length = LW'(2);
      end else begin
        start = 1'b0;
      end
    end
    check("p4_done_count", ndone, 1);

    // asynchronous reset in the middle of a SHIFT cycle
    pulse_start(4, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("p5_in_shift", {sel1, sel0}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("p5_async_sel", {sel1, sel0}, 2'b00);
    check("p5_async_flags", {load, busy, done}, 3'b000);
    check("p5_async_pos", pos, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("p5_idle_after_reset", {sel1, sel0, busy}, 3'b010);
    pulse_start(4, 1, 1'b0, 1'b0);
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      check("p5_clean_done", done, (k == 14));
    end

    // Random traffic against the model
    repeat (3000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      dir    = 1'($urandom);
      mode   = 1'($urandom);
      speed  = SW'($urandom_range(0, 3));
      length = LW'($urandom_range(0, 7));
    end
    start = 1'b0; stop = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
